// File: rtl/bit_stream_serializer.sv
// rtl/bit_stream_serializer.sv - parallel word to serial bit stream with valid/ready load handshake
module bit_stream_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(WIDTH - 2);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] sreg, sreg_next;
    logic             ser_out_next, ser_valid_next, done_next;
    logic             accept;

    assign load_ready = (state == IDLE) || (state == SHIFT && cnt == LAST);
    assign accept     = load_valid && load_ready;
    assign busy       = ser_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sreg      <= '0;
            ser_out   <= IDLE_LEVEL;
            ser_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            sreg      <= sreg_next;
            ser_out   <= ser_out_next;
            ser_valid <= ser_valid_next;
            done      <= done_next;
        end
    end

    // The first bit goes straight to ser_out on accept; sreg keeps the remaining bits.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        sreg_next      = sreg;
        ser_out_next   = IDLE_LEVEL;
        ser_valid_next = 1'b0;
        done_next      = 1'b0;
        if (accept) begin
            state_next     = SHIFT;
            cnt_next       = '0;
            ser_out_next   = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
            sreg_next      = MSB_FIRST ? (load_data << 1) : (load_data >> 1);
            ser_valid_next = 1'b1;
        end else if (state == SHIFT && cnt != LAST) begin
            cnt_next       = cnt + CNT_W'(1);
            ser_out_next   = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
            sreg_next      = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
            ser_valid_next = 1'b1;
            done_next      = (cnt == PRE_LAST);
        end else if (state == SHIFT) begin
            state_next = IDLE;
            cnt_next   = '0;
        end
    end
endmodule

// File: tb/tb_bit_stream_serializer.sv
// tb/tb_bit_stream_serializer.sv - directed self-checking bench for bit_stream_serializer
module tb_bit_stream_serializer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // instance A: WIDTH=4, MSB first, idle low
    logic       a_rst, a_lv, a_lr, a_so, a_sv, a_busy, a_done;
    logic [3:0] a_ld;
    // instance B: WIDTH=8, LSB first, idle low
    logic       b_rst, b_lv, b_lr, b_so, b_sv, b_busy, b_done;
    logic [7:0] b_ld;
    // instance C: WIDTH=8, MSB first, idle high
    logic       c_rst, c_lv, c_lr, c_so, c_sv, c_busy, c_done;
    logic [7:0] c_ld;

    bit_stream_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
        .clk(clk), .reset(a_rst), .load_valid(a_lv), .load_data(a_ld), .load_ready(a_lr),
        .ser_out(a_so), .ser_valid(a_sv), .busy(a_busy), .done(a_done));
    bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_b (
        .clk(clk), .reset(b_rst), .load_valid(b_lv), .load_data(b_ld), .load_ready(b_lr),
        .ser_out(b_so), .ser_valid(b_sv), .busy(b_busy), .done(b_done));
    bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_c (
        .clk(clk), .reset(c_rst), .load_valid(c_lv), .load_data(c_ld), .load_ready(c_lr),
        .ser_out(c_so), .ser_valid(c_sv), .busy(c_busy), .done(c_done));

    // Overlapping 1011 detector fed from instance A, as a downstream consumer would be.
    logic       det_clr = 1'b0;
    logic [2:0] hist;
    int         det_cnt;
    always @(posedge clk) begin
        if (det_clr) begin
            hist    <= 3'b000;
            det_cnt <= 0;
        end else if (a_sv) begin
            hist <= {hist[1:0], a_so};
            if ({hist, a_so} == 4'b1011) det_cnt <= det_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst = 0; b_rst = 0; c_rst = 0;
        a_lv = 1; a_ld = 4'b1011; b_lv = 0; b_ld = '0; c_lv = 0; c_ld = '0;
        tick(); tick();
        total++; if (a_so !== 1'b0) begin bad++; $display("FAIL reset_ser_out: got %b want 0", a_so); end
        total++; if (a_sv !== 1'b0) begin bad++; $display("FAIL reset_ser_valid: got %b want 0", a_sv); end
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        total++; if (a_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", a_done); end
        total++; if (a_lr !== 1'b1) begin bad++; $display("FAIL reset_load_ready: got %b want 1", a_lr); end
        total++; if (c_so !== 1'b1) begin bad++; $display("FAIL reset_idle_high: got %b want 1", c_so); end
        // load_valid already high when reset releases: first edge out of reset captures
        a_rst = 1; b_rst = 1; c_rst = 1;
        tick();
        total++; if (a_sv !== 1'b1) begin bad++; $display("FAIL first_capture_valid: got %b want 1", a_sv); end
        total++; if (a_so !== 1'b1) begin bad++; $display("FAIL first_capture_bit: got %b want 1", a_so); end
        a_lv = 0;
        for (int k = 1; k < 4; k++) tick();
        tick();
        total++; if (a_sv !== 1'b0) begin bad++; $display("FAIL first_capture_end: got %b want 0", a_sv); end
    endtask

    task automatic test_single_word();
        logic [3:0] exp = 4'b1011;
        det_clr = 1; tick(); det_clr = 0;
        a_lv = 1; a_ld = exp;
        tick();
        a_lv = 0; a_ld = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            total++; if (a_so !== exp[3-k] || a_sv !== 1'b1 || a_busy !== 1'b1)
                begin bad++; $display("FAIL single_bit%0d: got so=%b sv=%b busy=%b want so=%b sv=1 busy=1", k, a_so, a_sv, a_busy, exp[3-k]); end
            total++; if (a_done !== (k == 3) || a_lr !== (k == 3))
                begin bad++; $display("FAIL single_done_ready%0d: got done=%b ready=%b want %b", k, a_done, a_lr, (k == 3)); end
            tick();
        end
        total++; if (a_so !== 1'b0 || a_sv !== 1'b0 || a_done !== 1'b0)
            begin bad++; $display("FAIL single_idle: got so=%b sv=%b done=%b want 0 0 0", a_so, a_sv, a_done); end
        total++; if (det_cnt !== 1) begin bad++; $display("FAIL single_detect: got %0d want 1", det_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp = 8'b1011_1011;
        det_clr = 1; tick(); det_clr = 0;
        a_lv = 1; a_ld = 4'b1011;
        tick();
        for (int k = 0; k < 8; k++) begin
            total++; if (a_so !== exp[7-k] || a_sv !== 1'b1)
                begin bad++; $display("FAIL b2b_bit%0d: got so=%b sv=%b want so=%b sv=1", k, a_so, a_sv, exp[7-k]); end
            total++; if (a_done !== (k == 3 || k == 7))
                begin bad++; $display("FAIL b2b_done%0d: got %b want %b", k, a_done, (k == 3 || k == 7)); end
            tick();
            if (k == 3) a_lv = 0;
        end
        total++; if (a_sv !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", a_sv); end
        total++; if (det_cnt !== 2) begin bad++; $display("FAIL b2b_detect: got %0d want 2", det_cnt); end
    endtask

    task automatic test_held_load();
        logic [7:0] exp = 8'b1100_0110;
        a_lv = 1; a_ld = 4'b1100;
        tick();
        a_ld = 4'b0110;
        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin
                total++; if (a_lr !== (k == 3))
                    begin bad++; $display("FAIL held_ready%0d: got %b want %b", k, a_lr, (k == 3)); end
            end
            total++; if (a_so !== exp[7-k] || a_sv !== 1'b1)
                begin bad++; $display("FAIL held_bit%0d: got so=%b sv=%b want so=%b sv=1", k, a_so, a_sv, exp[7-k]); end
            tick();
            if (k == 3) begin a_lv = 0; a_ld = 4'b1111; end
        end
        total++; if (a_sv !== 1'b0) begin bad++; $display("FAIL held_idle: got %b want 0", a_sv); end
    endtask

    task automatic test_lsb_first();
        logic [7:0] exp = 8'hA5;
        b_lv = 1; b_ld = exp;
        tick();
        b_lv = 0; b_ld = 8'h00;
        for (int k = 0; k < 8; k++) begin
            total++; if (b_so !== exp[k] || b_sv !== 1'b1 || b_done !== (k == 7))
                begin bad++; $display("FAIL lsb_bit%0d: got so=%b sv=%b done=%b want so=%b sv=1 done=%b", k, b_so, b_sv, b_done, exp[k], (k == 7)); end
            tick();
        end
        total++; if (b_sv !== 1'b0 || b_so !== 1'b0) begin bad++; $display("FAIL lsb_idle: got sv=%b so=%b want 0 0", b_sv, b_so); end
    endtask

    task automatic test_reset_mid_word();
        b_lv = 1; b_ld = 8'hFF;
        tick();
        b_lv = 0;
        tick();
        total++; if (b_so !== 1'b1 || b_sv !== 1'b1) begin bad++; $display("FAIL midrst_bit1: got so=%b sv=%b want 1 1", b_so, b_sv); end
        b_rst = 0;
        #1;
        total++; if (b_so !== 1'b0 || b_sv !== 1'b0 || b_busy !== 1'b0 || b_done !== 1'b0)
            begin bad++; $display("FAIL midrst_async: got so=%b sv=%b busy=%b done=%b want 0 0 0 0", b_so, b_sv, b_busy, b_done); end
        total++; if (b_lr !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", b_lr); end
        tick(); tick();
        b_rst = 1;
        for (int k = 0; k < 10; k++) begin
            total++; if (b_sv !== 1'b0 || b_done !== 1'b0 || b_so !== 1'b0)
                begin bad++; $display("FAIL midrst_idle%0d: got sv=%b done=%b so=%b want 0 0 0", k, b_sv, b_done, b_so); end
            tick();
        end
    endtask

    task automatic test_idle_high();
        logic [7:0] exp = 8'h3C;
        for (int k = 0; k < 5; k++) begin
            total++; if (c_so !== 1'b1 || c_sv !== 1'b0)
                begin bad++; $display("FAIL idlehi_%0d: got so=%b sv=%b want 1 0", k, c_so, c_sv); end
            tick();
        end
        c_lv = 1; c_ld = exp;
        tick();
        c_lv = 0;
        for (int k = 0; k < 8; k++) begin
            total++; if (c_so !== exp[7-k] || c_sv !== 1'b1)
                begin bad++; $display("FAIL idlehi_bit%0d: got so=%b sv=%b want so=%b sv=1", k, c_so, c_sv, exp[7-k]); end
            tick();
        end
        total++; if (c_so !== 1'b1 || c_sv !== 1'b0) begin bad++; $display("FAIL idlehi_after: got so=%b sv=%b want 1 0", c_so, c_sv); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_held_load();
        test_lsb_first();
        test_reset_mid_word();
        test_idle_high();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
